main_decoder: RTL and testbench

- Main control decoder of the RV32I RISC processor. It maps the 7-bit instruction opcode to the datapath control signals: register write, immediate format, ALU source, memory write, result select, branch and ALU-op class.
- Sits between instruction fetch/decode and the ALU decoder and datapath. ALUOp feeds the separate ALU decoder.
- Outputs are registered by default, giving a pipeline-friendly one-cycle latency.

---
 rtl/main_decoder.sv | 97 +++++++++
 tb/tb_main_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/main_decoder.sv
// RV32I main control decoder: opcode -> datapath controls, registered (REG_OUT=1) or combinational.
// Optional jump/upper-immediate decode is enabled by defining RV32_JUMP_UPPER_EN.
module main_decoder #(
    parameter int WIDTH   = 7,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Op,
    output logic             RegWrite,
    output logic [1:0]       ImmSrc,
    output logic             ALUSrc,
    output logic             MemWrite,
    output logic             ResultSrc,
    output logic             Branch,
    output logic [1:0]       ALUOp,
`ifdef RV32_JUMP_UPPER_EN
    output logic             Jump,
    output logic             LinkSel,
    output logic [1:0]       UpperSel,
`endif
    output logic             Illegal
);

`ifdef RV32_JUMP_UPPER_EN
    localparam int CW = 14;
`else
    localparam int CW = 10;
`endif

    if (WIDTH != 7) begin : g_bad_width
        $error("main_decoder: only WIDTH=7 is supported");
    end

    // Control word layout, LSB first: Illegal, ALUOp[1:0], Branch, ResultSrc,
    // MemWrite, ALUSrc, ImmSrc[1:0], RegWrite, then UpperSel[1:0], LinkSel, Jump.
    function automatic logic [CW-1:0] decode_op(input logic [6:0] op);
        logic [CW-1:0] c;
        c = '0;
        case (op)
            7'b0000011: c[9:0] = 10'b1_00_1_0_1_0_00_0;
            7'b0100011: c[9:0] = 10'b0_01_1_1_0_0_00_0;
            7'b0110011: c[9:0] = 10'b1_00_0_0_0_0_10_0;
            7'b1100011: c[9:0] = 10'b0_10_0_0_0_1_01_0;
            7'b0010011: c[9:0] = 10'b1_00_1_0_0_0_10_0;
`ifdef RV32_JUMP_UPPER_EN
            7'b1101111: c = 14'b1_1_00_1_11_0_0_0_0_00_0;
            7'b1100111: c = 14'b1_1_00_1_00_1_0_0_0_00_0;
            7'b0110111: c = 14'b0_0_01_1_11_1_0_0_0_00_0;
            7'b0010111: c = 14'b0_0_10_1_11_1_0_0_0_00_0;
`endif
            // Unknown, reserved, X or Z opcodes all land here as a safe illegal NOP.
            default:    c[0] = 1'b1;
        endcase
        return c;
    endfunction

    logic [CW-1:0] ctrl_d;
    logic [CW-1:0] ctrl_s;

    // Next control word from the current opcode.
    always_comb begin
        ctrl_d = decode_op(Op);
    end

    if (REG_OUT) begin : g_reg
        logic [CW-1:0] ctrl_q;

        // Output register; reset forces the all-zero NOP word.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctrl_q <= '0;
            end else begin
                ctrl_q <= ctrl_d;
            end
        end

        assign ctrl_s = ctrl_q;
    end else begin : g_comb
        assign ctrl_s = ctrl_d;
    end

    assign Illegal   = ctrl_s[0];
    assign ALUOp     = ctrl_s[2:1];
    assign Branch    = ctrl_s[3];
    assign ResultSrc = ctrl_s[4];
    assign MemWrite  = ctrl_s[5];
    assign ALUSrc    = ctrl_s[6];
    assign ImmSrc    = ctrl_s[8:7];
    assign RegWrite  = ctrl_s[9];
`ifdef RV32_JUMP_UPPER_EN
    assign UpperSel  = ctrl_s[11:10];
    assign LinkSel   = ctrl_s[12];
    assign Jump      = ctrl_s[13];
`endif

endmodule

// File: tb/tb_main_decoder.sv
// Self-checking bench for main_decoder: vector table, reset corner cases and randomized opcodes.
module tb_main_decoder;

`ifdef RV32_JUMP_UPPER_EN
    localparam int CW = 14;
`else
    localparam int CW = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, Illegal;
    logic [1:0] ImmSrc, ALUOp;
`ifdef RV32_JUMP_UPPER_EN
    logic       Jump, LinkSel;
    logic [1:0] UpperSel;
`endif

    always #5 clk = ~clk;

    main_decoder #(.WIDTH(7), .REG_OUT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .Op(op),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
        .ResultSrc(ResultSrc), .Branch(Branch), .ALUOp(ALUOp),
`ifdef RV32_JUMP_UPPER_EN
        .Jump(Jump), .LinkSel(LinkSel), .UpperSel(UpperSel),
`endif
        .Illegal(Illegal)
    );

    // Observed word: {Jump, LinkSel, UpperSel,} RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Illegal
    logic [CW-1:0] obs;
`ifdef RV32_JUMP_UPPER_EN
    assign obs = {Jump, LinkSel, UpperSel, RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Illegal};
`else
    assign obs = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Illegal};
`endif

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: per-instruction field assignments straight from the decode rules.
    function automatic logic [CW-1:0] ref_ctrl(input logic [6:0] o);
        bit rw, asrc, mw, rsrc, br, ill, jmp, lnk;
        bit [1:0] imm, aop, up;
        {rw, asrc, mw, rsrc, br, ill, jmp, lnk} = 8'd0;
        imm = 2'd0; aop = 2'd0; up = 2'd0;
        if (o == 7'b0000011) begin rw = 1'b1; asrc = 1'b1; rsrc = 1'b1; end
        else if (o == 7'b0100011) begin imm = 2'd1; asrc = 1'b1; mw = 1'b1; end
        else if (o == 7'b0110011) begin rw = 1'b1; aop = 2'd2; end
        else if (o == 7'b1100011) begin imm = 2'd2; br = 1'b1; aop = 2'd1; end
        else if (o == 7'b0010011) begin rw = 1'b1; asrc = 1'b1; aop = 2'd2; end
`ifdef RV32_JUMP_UPPER_EN
        else if (o == 7'b1101111) begin rw = 1'b1; imm = 2'd3; jmp = 1'b1; lnk = 1'b1; end
        else if (o == 7'b1100111) begin rw = 1'b1; asrc = 1'b1; jmp = 1'b1; lnk = 1'b1; end
        else if (o == 7'b0110111) begin rw = 1'b1; imm = 2'd3; asrc = 1'b1; up = 2'd1; end
        else if (o == 7'b0010111) begin rw = 1'b1; imm = 2'd3; asrc = 1'b1; up = 2'd2; end
`endif
        else ill = 1'b1;
`ifdef RV32_JUMP_UPPER_EN
        return {jmp, lnk, up, rw, imm, asrc, mw, rsrc, br, aop, ill};
`else
        return {rw, imm, asrc, mw, rsrc, br, aop, ill};
`endif
    endfunction

    typedef struct {
        logic [6:0]    op;
        logic [CW-1:0] exp;
        string         name;
    } vec_t;

    vec_t vecs[$];
    logic [6:0] legal_ops[9];
    logic [6:0] prev_op;
    logic [CW-1:0] ld_exp, st_exp, it_exp, zero_w;

    initial begin
        zero_w = '0;
        ld_exp = CW'(10'b1_00_1_0_1_0_00_0);
        st_exp = CW'(10'b0_01_1_1_0_0_00_0);
        it_exp = CW'(10'b1_00_1_0_0_0_10_0);

        vecs.push_back('{7'b0100011, st_exp, "store"});
        vecs.push_back('{7'b0110011, CW'(10'b1_00_0_0_0_0_10_0), "rtype"});
        vecs.push_back('{7'b1100011, CW'(10'b0_10_0_0_0_1_01_0), "branch"});
        vecs.push_back('{7'b0010011, it_exp, "itype"});
        vecs.push_back('{7'b0000011, ld_exp, "load"});
`ifdef RV32_JUMP_UPPER_EN
        vecs.push_back('{7'b1101111, 14'b1_1_00_1_11_0_0_0_0_00_0, "jal"});
        vecs.push_back('{7'b1100111, 14'b1_1_00_1_00_1_0_0_0_00_0, "jalr"});
        vecs.push_back('{7'b0110111, 14'b0_0_01_1_11_1_0_0_0_00_0, "lui"});
        vecs.push_back('{7'b0010111, 14'b0_0_10_1_11_1_0_0_0_00_0, "auipc"});
`else
        vecs.push_back('{7'b0110111, CW'(10'b0_00_0_0_0_0_00_1), "lui_illegal"});
        vecs.push_back('{7'b0010111, CW'(10'b0_00_0_0_0_0_00_1), "auipc_illegal"});
        vecs.push_back('{7'b1101111, CW'(10'b0_00_0_0_0_0_00_1), "jal_illegal"});
        vecs.push_back('{7'b1100111, CW'(10'b0_00_0_0_0_0_00_1), "jalr_illegal"});
`endif
        vecs.push_back('{7'b1111111, CW'(10'b0_00_0_0_0_0_00_1), "ones_illegal"});
        vecs.push_back('{7'b0000000, CW'(10'b0_00_0_0_0_0_00_1), "zero_illegal"});

        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

        // Reset held across two edges with a load opcode present.
        rst_n = 1'b0;
        op    = 7'b0000011;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hold", obs, zero_w);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release_load", obs, ld_exp);

        // Table sweep, one opcode per 10 ns, checked one cycle later.
        foreach (vecs[i]) begin
            op = vecs[i].op;
            @(negedge clk);
            check(vecs[i].name, obs, vecs[i].exp);
        end

        // Held I-type: checked just after each edge and mid-cycle.
        op = 7'b0010011;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("itype_hold_edge", obs, it_exp);
            @(negedge clk);
            check("itype_hold_mid", obs, it_exp);
        end

        // Asynchronous reset mid-stream with a store in flight.
        op = 7'b0100011;
        @(negedge clk);
        check("store_before_reset", obs, st_exp);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_drop", obs, zero_w);
        @(negedge clk);
        check("reset_held_store", obs, zero_w);
        rst_n = 1'b1;
        @(negedge clk);
        check("store_after_release", obs, st_exp);

        // Random opcode every cycle; each output lags its opcode by exactly one cycle.
        prev_op = 7'b0110011;
        op      = prev_op;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            check("random", obs, ref_ctrl(prev_op));
            if ($urandom_range(0, 1) == 0) begin
                prev_op = legal_ops[$urandom_range(0, 8)];
            end else begin
                prev_op = 7'($urandom_range(0, 127));
            end
            op = prev_op;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
